// File: rtl/exu_pkg.sv
// Shared definitions for the execute-stage controller: ALU op bit indices,
// sequencer states and the MUL-op decode helper.
package exu_pkg;

  localparam int unsigned ALU_OP_WIDTH = 10;
  localparam int unsigned ALU_OP_ADD   = 0;
  localparam int unsigned ALU_OP_MUL   = 9;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    WB
  } exu_state_t;

  // Only a clean one-hot MUL selects the iterative multiplier; anything else is single-cycle.
  function automatic logic is_mul_op(input logic [ALU_OP_WIDTH-1:0] op);
    return op == ALU_OP_WIDTH'(1 << ALU_OP_MUL);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU; produces the sum when the ADD bit is set, else zero.
module alu
  import exu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   result
);

  logic unused_op_bits;
  assign unused_op_bits = ^op[ALU_OP_WIDTH-1:ALU_OP_ADD+1];

  always_comb begin
    result = '0;
    if (op[ALU_OP_ADD]) result = a + b;
  end

endmodule

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier datapath; one partial product per step,
// done strobes on the last step with the low product word on product.
module exu_mul_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign done     = step && (count == CW'(DATA_WIDTH - 1));
  // Final step's addend is folded in combinationally so the result lands with done.
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

endmodule

// File: rtl/exu_ctrl.sv
// Execute-stage sequencer: accepts decoded ops over valid/ready, runs
// single-cycle ops through alu and MUL through exu_mul_iter, holds results for write-back.
module exu_ctrl
  import exu_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_OP_WIDTH-1:0]   aluOp,
  input  logic [DATA_WIDTH-1:0]     aluSrc1,
  input  logic [DATA_WIDTH-1:0]     aluSrc2,
  input  logic                      d_regW,
  input  logic [REG_ADDR_WIDTH-1:0] d_regAddr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      e_regW,
  output logic [REG_ADDR_WIDTH-1:0] e_regAddr,
  output logic [DATA_WIDTH-1:0]     e_regData,
  output logic                      busy
);

  exu_state_t            state, state_next;
  logic                  fire;
  logic                  mul_op;
  logic                  mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] alu_result;

  assign fire   = in_valid && in_ready;
  assign mul_op = is_mul_op(aluOp);

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (aluOp),
    .a      (aluSrc1),
    .b      (aluSrc2),
    .result (alu_result)
  );

  exu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (fire && mul_op),
    .step    (state == MUL),
    .a       (aluSrc1),
    .b       (aluSrc2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (fire) state_next = mul_op ? MUL : WB;
      MUL:  if (mul_done) state_next = WB;
      WB: begin
        if (fire)           state_next = mul_op ? MUL : WB;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == WB) && out_ready);
    out_valid = (state == WB);
    busy      = (state == MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_regW    <= 1'b0;
      e_regAddr <= '0;
      e_regData <= '0;
    end else if (fire) begin
      e_regW    <= d_regW && (|d_regAddr);
      e_regAddr <= d_regAddr;
      if (!mul_op) e_regData <= alu_result;
    end else if (mul_done) begin
      e_regData <= mul_product;
    end
  end

endmodule

// File: tb/tb_exu_ctrl.sv
// Directed self-checking bench for exu_ctrl with hand-computed expectations.
module tb_exu_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam logic [9:0] OP_ADD = 10'h001;
  localparam logic [9:0] OP_MUL = 10'h200;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [9:0]    aluOp;
  logic [DW-1:0] aluSrc1;
  logic [DW-1:0] aluSrc2;
  logic          d_regW;
  logic [AW-1:0] d_regAddr;
  logic          out_valid;
  logic          out_ready;
  logic          e_regW;
  logic [AW-1:0] e_regAddr;
  logic [DW-1:0] e_regData;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  exu_ctrl #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluOp     (aluOp),
    .aluSrc1   (aluSrc1),
    .aluSrc2   (aluSrc2),
    .d_regW    (d_regW),
    .d_regAddr (d_regAddr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e_regW    (e_regW),
    .e_regAddr (e_regAddr),
    .e_regData (e_regData),
    .busy      (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [9:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic w, input logic [AW-1:0] addr);
    in_valid  = v;
    aluOp     = op;
    aluSrc1   = a;
    aluSrc2   = b;
    d_regW    = w;
    d_regAddr = addr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (e_regW !== 1'b0) begin n_bad++; $display("FAIL reset_e_regW: got %0b want 0", e_regW); end
    n_cmp++; if (e_regAddr !== 5'd0) begin n_bad++; $display("FAIL reset_e_regAddr: got %0d want 0", e_regAddr); end
    n_cmp++; if (e_regData !== 32'd0) begin n_bad++; $display("FAIL reset_e_regData: got %h want 0", e_regData); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd5, 32'd7, 1'b1, 5'd3);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready_pre: got %0b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_out_valid: got %0b want 1", out_valid); end
    n_cmp++; if (e_regData !== 32'd12) begin n_bad++; $display("FAIL add_data: got %0d want 12", e_regData); end
    n_cmp++; if (e_regAddr !== 5'd3) begin n_bad++; $display("FAIL add_addr: got %0d want 3", e_regAddr); end
    n_cmp++; if (e_regW !== 1'b1) begin n_bad++; $display("FAIL add_regW: got %0b want 1", e_regW); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready_wb: got %0b want 1", in_ready); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_retire: got %0b want 0", out_valid); end
  endtask

  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    int k;
    out_ready = 1'b1;
    drive(1'b1, OP_MUL, a, b, 1'b1, addr);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_in_ready_pre: got %0b want 1", in_ready); end
    cyc();
    drive(1'b0, OP_ADD, 32'd1, 32'd1, 1'b1, 5'd1);
    #1;
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_busy_c%0d: busy=%0b in_ready=%0b want 1/0", k, busy, in_ready); end
      cyc();
      k++;
    end
    n_cmp++; if (k != 33) begin n_bad++; $display("FAIL mul_latency: got %0d want 33", k); end
    n_cmp++; if (e_regData !== exp) begin n_bad++; $display("FAIL mul_data: got %h want %h", e_regData, exp); end
    n_cmp++; if (e_regAddr !== addr || e_regW !== 1'b1) begin n_bad++; $display("FAIL mul_dest: got %0d/%0b want %0d/1", e_regAddr, e_regW, addr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mul_busy_wb: got %0b want 0", busy); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mul_retire: got %0b want 0", out_valid); end
  endtask

  task automatic test_mul();
    run_mul(32'hFFFF_FFFF, 32'd3, 5'd4, 32'hFFFF_FFFD);
    run_mul(32'd7, 32'd6, 5'd5, 32'd42);
    run_mul(32'h0001_0000, 32'h0001_0000, 5'd6, 32'd0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'd1);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd1, 1'b1, 5'd5);
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || e_regData !== 32'd2) begin n_bad++; $display("FAIL b2b_first: valid=%0b data=%0d want 1/2", out_valid, e_regData); end
    drive(1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 5'd6);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || e_regData !== 32'd4 || e_regAddr !== 5'd6) begin n_bad++; $display("FAIL b2b_second: valid=%0b data=%0d addr=%0d want 1/4/6", out_valid, e_regData, e_regAddr); end
    drive(1'b1, OP_ADD, 32'd3, 32'd3, 1'b1, 5'd7);
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || e_regData !== 32'd6 || e_regAddr !== 5'd7) begin n_bad++; $display("FAIL b2b_third: valid=%0b data=%0d addr=%0d want 1/6/7", out_valid, e_regData, e_regAddr); end
    in_valid = 1'b0;
    cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'd10, 32'd20, 1'b1, 5'd8);
    cyc();
    drive(1'b1, OP_ADD, 32'd100, 32'd1, 1'b1, 5'd9);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (out_valid !== 1'b1 || e_regData !== 32'd30 || e_regAddr !== 5'd8 || in_ready !== 1'b0)
        begin n_bad++; $display("FAIL stall_c%0d: valid=%0b data=%0d addr=%0d in_ready=%0b want 1/30/8/0", i, out_valid, e_regData, e_regAddr, in_ready); end
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %0b want 1", in_ready); end
    cyc();
    n_cmp++; if (out_valid !== 1'b0 || e_regData !== 32'd30) begin n_bad++; $display("FAIL stall_retire: valid=%0b data=%0d want 0/30", out_valid, e_regData); end
  endtask

  task automatic test_x0();
    out_ready = 1'b1;
    drive(1'b1, OP_ADD, 32'd9, 32'd9, 1'b1, 5'd0);
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (e_regW !== 1'b0) begin n_bad++; $display("FAIL x0_regW: got %0b want 0", e_regW); end
    n_cmp++; if (e_regData !== 32'd18 || out_valid !== 1'b1) begin n_bad++; $display("FAIL x0_data: data=%0d valid=%0b want 18/1", e_regData, out_valid); end
    cyc();
  endtask

  task automatic test_odd_ops();
    out_ready = 1'b1;
    drive(1'b1, 10'h000, 32'd3, 32'd4, 1'b1, 5'd10);
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0 || e_regData !== 32'd0) begin n_bad++; $display("FAIL op_zero: valid=%0b busy=%0b data=%0d want 1/0/0", out_valid, busy, e_regData); end
    drive(1'b1, 10'h201, 32'd3, 32'd4, 1'b1, 5'd11);
    cyc();
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0 || e_regData !== 32'd7) begin n_bad++; $display("FAIL op_multi: valid=%0b busy=%0b data=%0d want 1/0/7", out_valid, busy, e_regData); end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_rst_mid_mul();
    logic seen;
    out_ready = 1'b1;
    drive(1'b1, OP_MUL, 32'd5, 32'd5, 1'b1, 5'd12);
    cyc();
    in_valid = 1'b0;
    repeat (9) cyc();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmul_busy_before: got %0b want 1", busy); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmul_state: valid=%0b busy=%0b in_ready=%0b want 0/0/1", out_valid, busy, in_ready); end
    n_cmp++; if (e_regData !== 32'd0 || e_regW !== 1'b0 || e_regAddr !== 5'd0) begin n_bad++; $display("FAIL rstmul_regs: data=%0d w=%0b addr=%0d want 0/0/0", e_regData, e_regW, e_regAddr); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      cyc();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmul_dropped: got %0b want 0", seen); end
    drive(1'b1, OP_ADD, 32'd2, 32'd2, 1'b1, 5'd13);
    cyc();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || e_regData !== 32'd4 || e_regAddr !== 5'd13 || e_regW !== 1'b1)
      begin n_bad++; $display("FAIL rstmul_add: valid=%0b data=%0d addr=%0d w=%0b want 1/4/13/1", out_valid, e_regData, e_regAddr, e_regW); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_stall();
    test_x0();
    test_odd_ops();
    test_rst_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
